// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: 5..DBITS_MAX data bits,
// none/even/odd/mark parity, 1/1.5/2 stop bits and break generation.
module uart_tx_cfg #(
  parameter int DBITS_MAX  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk_100MHz,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 tx_start,
  input  logic [DBITS_MAX-1:0] data_in,
  input  logic [4:0]           cfg_dbits,
  input  logic [1:0]           cfg_parity,
  input  logic [1:0]           cfg_stop,
  input  logic                 send_break,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx
);

  localparam int TW = $clog2(2 * OVERSAMPLE);
  localparam logic [TW-1:0] T_BIT = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_S15 = TW'(OVERSAMPLE * 3 / 2 - 1);
  localparam logic [TW-1:0] T_S2  = TW'(2 * OVERSAMPLE - 1);
  localparam logic [4:0]    DMAX  = 5'(DBITS_MAX);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BREAK
  } state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [4:0]           bit_q, bit_d;
  logic [DBITS_MAX-1:0] shift_q, shift_d;
  logic [DBITS_MAX-1:0] data_q, data_d;
  logic [4:0]           dbits_q, dbits_d;
  logic [1:0]           par_q, par_d;
  logic [1:0]           stop_q, stop_d;
  logic                 done_q, done_d;
  logic                 tx_q, tx_d;
  logic [4:0]           dbits_clamp;
  logic [TW-1:0]        last_tick;
  logic                 bit_end;
  logic                 par_x;
  logic                 par_bit;

  assign dbits_clamp = (cfg_dbits < 5'd5) ? 5'd5 :
                       (cfg_dbits > DMAX) ? DMAX : cfg_dbits;

  always_comb begin
    last_tick = T_BIT;
    if (state_q == STOP) begin
      unique case (stop_q)
        2'b00:   last_tick = T_BIT;
        2'b01:   last_tick = T_S15;
        default: last_tick = T_S2;
      endcase
    end
  end

  assign bit_end = sample_tick && (tick_q == last_tick);

  // Parity comes from the latched word, never the shifting copy.
  always_comb begin
    par_x = 1'b0;
    for (int i = 0; i < DBITS_MAX; i++) begin
      if (5'(i) < dbits_q) par_x = par_x ^ data_q[i];
    end
    unique case (par_q)
      2'b01:   par_bit = par_x;
      2'b10:   par_bit = ~par_x;
      default: par_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      dbits_q <= 5'd5;
      par_q   <= '0;
      stop_q  <= '0;
      done_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      dbits_q <= dbits_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    dbits_d = dbits_q;
    par_d   = par_q;
    stop_d  = stop_q;
    done_d  = 1'b0;
    if (sample_tick && state_q != IDLE && state_q != BREAK)
      tick_d = bit_end ? '0 : tick_q + TW'(1);
    unique case (state_q)
      IDLE: begin
        tick_d = '0;
        if (tx_start) begin
          state_d = START;
          data_d  = data_in;
          shift_d = data_in;
          dbits_d = dbits_clamp;
          par_d   = cfg_parity;
          stop_d  = cfg_stop;
          bit_d   = '0;
        end else if (send_break) begin
          state_d = BREAK;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == dbits_q - 5'd1)
            state_d = (par_q != 2'b00) ? PARITY : STOP;
          else
            bit_d = bit_q + 5'd1;
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      BREAK: begin
        tick_d = '0;
        if (!send_break) begin
          state_d = STOP;
          stop_d  = cfg_stop;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      PARITY:  tx_d = par_bit;
      BREAK:   tx_d = 1'b0;
      default: tx_d = 1'b1;
    endcase
  end

  assign tx_busy = (state_q != IDLE);
  assign tx_done = done_q;
  assign tx      = tx_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: hand-written frame table, corner sequences,
// and random frames checked against a per-tick line model.
module tb_uart_tx_cfg;

  localparam int DM = 8;
  localparam int OS = 16;

  logic          clk_100MHz = 1'b0;
  logic          reset;
  logic          sample_tick;
  logic          tx_start;
  logic [DM-1:0] data_in;
  logic [4:0]    cfg_dbits;
  logic [1:0]    cfg_parity;
  logic [1:0]    cfg_stop;
  logic          send_break;
  logic          tx_busy;
  logic          tx_done;
  logic          tx;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int cyc_n    = 0;
  bit tick_rnd = 1'b0;
  bit m_busy_prev = 1'b0;
  bit m_st_prev   = 1'b0;
  logic obs_q[$];
  logic exp_q[$];

  typedef struct {
    logic [7:0]  d;
    logic [4:0]  db;
    logic [1:0]  p;
    logic [1:0]  s;
    logic [11:0] lv;
    int          nb;
    int          st;
  } vec_t;

  vec_t tbl[10];

  uart_tx_cfg #(.DBITS_MAX(DM), .OVERSAMPLE(OS)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .sample_tick(sample_tick),
    .tx_start   (tx_start),
    .data_in    (data_in),
    .cfg_dbits  (cfg_dbits),
    .cfg_parity (cfg_parity),
    .cfg_stop   (cfg_stop),
    .send_break (send_break),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx         (tx)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  // tx in this cycle shows the state of the previous one, so it is
  // paired with the previous cycle's busy flag and tick.
  always @(negedge clk_100MHz) begin
    if (m_busy_prev && m_st_prev) obs_q.push_back(tx);
    if (tx_done) done_cnt++;
    if (tx_busy) busy_cnt++;
    m_busy_prev = tx_busy;
    m_st_prev   = sample_tick;
  end

  task automatic cyc();
    @(posedge clk_100MHz);
    #1;
    cyc_n++;
    sample_tick = tick_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, req);
    end
  endtask

  task automatic cmp_seq(input string nm);
    int bad;
    bad = -1;
    checks++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
    if (bad >= 0 || obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s ticks %0d required %0d first_bad_tick %0d",
               nm, obs_q.size(), exp_q.size(), bad);
    end
  endtask

  task automatic add_run(input logic lvl, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(lvl);
  endtask

  // Line model: per-tick levels of one frame built from the frame rules.
  task automatic add_frame(input logic [7:0] d, input int db,
                           input int p, input int s);
    int n, ones;
    logic pv;
    n = (db < 5) ? 5 : (db > DM) ? DM : db;
    ones = 0;
    add_run(1'b0, OS);
    for (int i = 0; i < n; i++) begin
      add_run(d[i], OS);
      if (d[i]) ones++;
    end
    if (p != 0) begin
      pv = (p == 1) ? 1'((ones % 2) == 1) :
           (p == 2) ? 1'((ones % 2) == 0) : 1'b1;
      add_run(pv, OS);
    end
    add_run(1'b1, (s == 0) ? OS : (s == 1) ? OS + OS / 2 : 2 * OS);
  endtask

  task automatic add_table(input vec_t v);
    for (int i = 0; i < v.nb; i++) add_run(v.lv[i], OS);
    add_run(1'b1, v.st);
  endtask

  task automatic wait_done(input int target);
    int g;
    g = 0;
    while (done_cnt < target && g < 4000) begin
      cyc();
      g++;
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input logic [4:0] db,
                           input logic [1:0] p, input logic [1:0] s,
                           input bit brk, input string nm,
                           output int lat, output int bz);
    int d0, b0;
    obs_q.delete();
    d0 = done_cnt;
    b0 = busy_cnt;
    data_in    = d;
    cfg_dbits  = db;
    cfg_parity = p;
    cfg_stop   = s;
    send_break = brk;
    tx_start   = 1'b1;
    cyc();
    tx_start   = 1'b0;
    send_break = 1'b0;
    if (tick_rnd) begin
      data_in    = DM'($urandom);
      cfg_dbits  = 5'($urandom);
      cfg_parity = 2'($urandom);
      cfg_stop   = 2'($urandom);
    end
    lat = 0;
    while (done_cnt == d0 && lat < 4000) begin
      cyc();
      lat++;
    end
    cyc();
    cyc();
    bz = busy_cnt - b0;
    chk({nm, "_done"}, done_cnt - d0, 1);
  endtask

  initial begin
    int lat, bz, d0, c0;
    logic [7:0] rd;
    logic [4:0] rdb;
    logic [1:0] rp, rs;

    tbl[0] = '{8'hA5, 5'd8,  2'd0, 2'd0, 12'h14A, 9,  16};
    tbl[1] = '{8'h35, 5'd7,  2'd1, 2'd0, 12'h06A, 9,  16};
    tbl[2] = '{8'h1F, 5'd5,  2'd2, 2'd2, 12'h03E, 7,  32};
    tbl[3] = '{8'h00, 5'd8,  2'd3, 2'd0, 12'h200, 10, 16};
    tbl[4] = '{8'hFF, 5'd6,  2'd3, 2'd0, 12'h0FE, 8,  16};
    tbl[5] = '{8'h00, 5'd8,  2'd0, 2'd1, 12'h000, 9,  24};
    tbl[6] = '{8'hE6, 5'd3,  2'd0, 2'd0, 12'h00C, 6,  16};
    tbl[7] = '{8'h81, 5'd12, 2'd1, 2'd3, 12'h102, 10, 32};
    tbl[8] = '{8'h01, 5'd7,  2'd1, 2'd0, 12'h102, 9,  16};
    tbl[9] = '{8'h3C, 5'd8,  2'd2, 2'd0, 12'h278, 10, 16};

    reset = 1'b1;
    sample_tick = 1'b1;
    tx_start = 1'b0;
    send_break = 1'b0;
    data_in = '0;
    cfg_dbits = 5'd8;
    cfg_parity = 2'd0;
    cfg_stop = 2'd0;
    repeat (3) cyc();
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(tx_busy), 0);
    chk("rst_done", int'(tx_done), 0);
    reset = 1'b0;
    repeat (3) cyc();
    chk("idle_tx", int'(tx), 1);
    chk("idle_busy", int'(tx_busy), 0);

    for (int i = 0; i < 10; i++) begin
      exp_q.delete();
      add_table(tbl[i]);
      run_frame(tbl[i].d, tbl[i].db, tbl[i].p, tbl[i].s, 1'b0,
                $sformatf("vec%0d", i), lat, bz);
      cmp_seq($sformatf("vec%0d_seq", i));
      chk($sformatf("vec%0d_lat", i), lat, tbl[i].nb * OS + tbl[i].st + 1);
      chk($sformatf("vec%0d_busy", i), bz, tbl[i].nb * OS + tbl[i].st);
    end

    // Back-to-back with tx_start held and config changed mid-frame.
    obs_q.delete();
    exp_q.delete();
    d0 = done_cnt;
    data_in = 8'h96; cfg_dbits = 5'd8; cfg_parity = 2'd0; cfg_stop = 2'd0;
    add_frame(8'h96, 8, 0, 0);
    tx_start = 1'b1;
    cyc();
    c0 = cyc_n;
    repeat (20) cyc();
    data_in = 8'h4B; cfg_dbits = 5'd6; cfg_parity = 2'd1; cfg_stop = 2'd1;
    add_frame(8'h4B, 6, 1, 1);
    wait_done(d0 + 1);
    repeat (20) cyc();
    data_in = 8'hC3; cfg_dbits = 5'd7; cfg_parity = 2'd2; cfg_stop = 2'd2;
    add_frame(8'hC3, 7, 2, 2);
    wait_done(d0 + 2);
    repeat (20) cyc();
    tx_start = 1'b0;
    data_in = 8'h00; cfg_dbits = 5'd5; cfg_parity = 2'd3; cfg_stop = 2'd0;
    wait_done(d0 + 3);
    chk("b2b_span", cyc_n - c0, exp_q.size() + 3);
    repeat (40) cyc();
    cmp_seq("b2b_seq");
    chk("b2b_done", done_cnt - d0, 3);
    chk("b2b_idle", int'(tx_busy), 0);

    // Long break, one stop bit.
    obs_q.delete();
    exp_q.delete();
    d0 = done_cnt;
    cfg_stop = 2'd0;
    send_break = 1'b1;
    cyc();
    repeat (800) cyc();
    send_break = 1'b0;
    wait_done(d0 + 1);
    repeat (2) cyc();
    add_run(1'b0, 801);
    add_run(1'b1, OS);
    cmp_seq("brk_seq");
    chk("brk_done", done_cnt - d0, 1);

    // Break stop length taken from cfg_stop at release.
    obs_q.delete();
    exp_q.delete();
    d0 = done_cnt;
    send_break = 1'b1;
    cyc();
    repeat (100) cyc();
    cfg_stop = 2'd2;
    repeat (10) cyc();
    send_break = 1'b0;
    wait_done(d0 + 1);
    repeat (2) cyc();
    add_run(1'b0, 111);
    add_run(1'b1, 2 * OS);
    cmp_seq("brk2_seq");
    chk("brk2_done", done_cnt - d0, 1);

    // tx_start beats send_break.
    exp_q.delete();
    add_frame(8'h5A, 8, 0, 0);
    run_frame(8'h5A, 5'd8, 2'd0, 2'd0, 1'b1, "prio", lat, bz);
    cmp_seq("prio_seq");

    // Reset in the middle of data bit 4.
    d0 = done_cnt;
    data_in = 8'h00; cfg_dbits = 5'd8; cfg_parity = 2'd0; cfg_stop = 2'd0;
    tx_start = 1'b1;
    cyc();
    tx_start = 1'b0;
    repeat (88) cyc();
    chk("pre_rst_tx", int'(tx), 0);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_tx", int'(tx), 1);
    chk("midrst_busy", int'(tx_busy), 0);
    repeat (3) cyc();
    reset = 1'b0;
    repeat (3) cyc();
    chk("midrst_nodone", done_cnt - d0, 0);
    exp_q.delete();
    add_frame(8'h3C, 8, 0, 0);
    run_frame(8'h3C, 5'd8, 2'd0, 2'd0, 1'b0, "postrst", lat, bz);
    cmp_seq("postrst_seq");

    // Random frames, random tick spacing, inputs scrambled mid-frame.
    tick_rnd = 1'b1;
    for (int k = 0; k < 40; k++) begin
      rd  = 8'($urandom);
      rdb = 5'($urandom);
      rp  = 2'($urandom);
      rs  = 2'($urandom);
      exp_q.delete();
      add_frame(rd, int'(rdb), int'(rp), int'(rs));
      run_frame(rd, rdb, rp, rs, 1'b0, $sformatf("rnd%0d", k), lat, bz);
      cmp_seq($sformatf("rnd%0d_seq", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Runtime-configurable UART transmitter, successor to the fixed 8N1 transmitter in the UART system. Per frame it supports 5..DBITS_MAX data bits, none/even/odd/mark parity, 1, 1.5 or 2 stop bits, and break generation. Each frame's configuration is latched when the frame starts. It sits between the TX FIFO (tx_start = FIFO not empty) and the pin, and is paced by the shared baud-rate generator's oversampling tick.

## Interface
- DBITS_MAX, 8, width of data_in; maximum data bits per frame (5..16)
- OVERSAMPLE, 16, sample_ticks per bit period (even, >= 4)

- clk_100MHz  in  1  system clock
- reset  in  1  asynchronous, active-high
- sample_tick  in  1  one-clk pulse from baud generator, OVERSAMPLE per bit
- tx_start  in  1  request to send data_in
- data_in  in  DBITS_MAX  frame data, LSB transmitted first
- cfg_dbits  in  5  data bits: <5 → 5, >DBITS_MAX → DBITS_MAX
- cfg_parity  in  2  00 none, 01 even, 10 odd, 11 mark (always 1)
- cfg_stop  in  2  00 one, 01 one-and-half, 10/11 two stop bits
- send_break  in  1  hold line low while high
- tx_busy  out  1  high whenever state ≠ IDLE
- tx_done  out  1  one-clk pulse at end of frame or break
- tx  out  1  serial line, registered

## Operation
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE has an accept priority:
  - tx_start=1: latch data_in, the clamped cfg_dbits, cfg_parity and cfg_stop; go to START. Tick counter is 0.
  - else send_break=1: go to BREAK.
  - Changes to cfg_* mid-frame have no effect.
- Bit timing:
  - The tick counter increments only on sample_tick.
  - A bit ends on the sample_tick where counter = length−1. The counter then clears.
  - START, DATA and PARITY bits last OVERSAMPLE ticks each.
  - STOP lasts OVERSAMPLE, 3·OVERSAMPLE/2 or 2·OVERSAMPLE ticks.
- DATA:
  - Line level = shift_reg[0]; the shift register shifts right at each bit end.
  - A bit counter counts to dbits−1, then goes to PARITY if parity ≠ none, else STOP.
- Parity value:
  - Even: XOR of the dbits LSBs of the latched data.
  - Odd: inverse of that XOR.
  - Mark: 1.
  - Computed from latched data, not from the shifting register.
- STOP: line high. At the end goes to IDLE and pulses tx_done.
- BREAK:
  - Line low while send_break=1.
  - When send_break is sampled 0, enter STOP using the current cfg_stop length, then IDLE with a tx_done pulse.
- tx_start while tx_busy=1 is ignored. The FIFO must hold its word until acceptance.
- Line level per state: IDLE 1, START 0, DATA data bit, PARITY parity bit, STOP 1, BREAK 0.

## Timing
- Reset values: tx=1, tx_busy=0, tx_done=0, state IDLE, counters 0.
- Reset mid-frame aborts immediately: tx=1 asynchronously, no tx_done.
- tx is a register of the current state's line level, so it lags the state register by one clk.
- tx_busy rises the clk after acceptance and falls in the same cycle as the tx_done pulse.
- tx_done is registered: it is high for exactly one clk, the cycle the state register first reads IDLE.
- Back-to-back frames:
  - tx_start held high is accepted in the first IDLE cycle, i.e. the same cycle tx_done is high.
  - The new START begins at the next clk; no idle bit is inserted.
- Frame length in sample_ticks = OVERSAMPLE·(1 + dbits + parity_en) + stop_ticks.
- Tick counter width is clog2(2·OVERSAMPLE). It must not overflow at 2·OVERSAMPLE−1.
- sample_tick is ignored in IDLE.

## Test plan
- Test 1 (8N1):
  - Setup: sample_tick=1 every clk, cfg 8N1, data_in=0xA5.
  - Required: tx = 0, then 1,0,1,0,0,1,0,1, then 1; each bit 16 clks, 160 ticks total.
  - Required: tx_done one clk after the stop bit ends; tx_busy high for the whole frame.
- Test 2 (parity):
  - 7E1, 0x35: 7 data bits 1,0,1,0,1,1,0 (LSB first), parity 0, total 10 bits.
  - 5O2, 0x1F: parity 0, stop 32 ticks.
  - Mark parity: parity bit is 1 for any data.
- Test 3 (stop and clamping):
  - 8N1.5: stop high for exactly 24 ticks.
  - cfg_dbits=3: behaves as 5 bits.
  - cfg_dbits=12 with DBITS_MAX=8: behaves as 8 bits.
- Test 4 (back-to-back and config latching):
  - Setup: tx_start held high for 3 frames; cfg changed mid-frame.
  - Required: exactly 3 frames with no gap between stop and next start.
  - Required: 3 tx_done pulses.
  - Required: each frame uses the config latched at its own start.
- Test 5 (break):
  - Setup: send_break high for 50 bit periods while idle, with tx_start=0.
  - Required: tx low throughout, then a 1-stop-bit high period, then tx_done.
  - Required: with tx_start and send_break both asserted in IDLE, the data frame wins.
- Test 6 (reset):
  - Setup: assert reset in the middle of DATA bit 4.
  - Required: tx=1 and tx_busy=0 immediately, no tx_done.
  - Required: after release, the next 0x3C 8N1 frame is bit-exact.
